// File: rtl/dmem_bank.sv
// ---------------------------------------------------------------------------
// dmem_bank
//
// Parametrised synchronous data memory for the MEM pipeline stage.
// Word-addressed array of 2**ADDR_W words, DATA_W bits each, with per-byte
// write enables and a registered read port. A read that hits the word being
// written in the same cycle returns the merged (write-first) word.
//
// A sequential clear engine zeroes one word per cycle, starting after every
// reset cycle and on a clr pulse. While it runs it owns the array, reports
// busy, and all access requests are dropped.
//
// Parameters
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  address width, DEPTH = 2**ADDR_W
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-low reset
//   a        in   word address shared by read and write
//   d        in   write data
//   we       in   write request
//   be       in   byte-lane enables, bit i gates d[8i+7:8i]
//   re       in   read request
//   clr      in   one-cycle pulse starting a full clear sweep
//   q        out  registered read data (0 when not reading)
//   q_valid  out  high for the cycle in which q holds read data
//   busy     out  high while the clear engine owns the array
// ---------------------------------------------------------------------------
module dmem_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     a,
    input  logic [DATA_W-1:0]     d,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  re,
    input  logic                  clr,
    output logic [DATA_W-1:0]     q,
    output logic                  q_valid,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    logic              state;
    logic [ADDR_W-1:0] cptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;
    logic              idle_access;
    logic              do_write;

    // A normal access only happens out of reset, in IDLE, and when no clear
    // is being requested in the same cycle.
    assign idle_access = rst && (state == ST_IDLE) && !clr;
    assign do_write    = idle_access && we;

    // Write-first view of the addressed word: enabled lanes take the new
    // data, the rest keep the stored bytes. Used both as the value written
    // back and as the forwarded read data.
    always_comb begin
        merged = mem[a];
        for (int i = 0; i < NB; i++) begin
            if (we && be[i]) begin
                merged[8*i +: 8] = d[8*i +: 8];
            end
        end
    end

    // Array update. The array itself is not reset; the clear engine zeroes
    // it one word per cycle instead, and no write occurs in a reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_CLEAR) begin
                mem[cptr] <= '0;
            end else if (do_write) begin
                mem[a] <= merged;
            end
        end
    end

    // Control: clear sequencer, busy flag and registered read port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            cptr    <= '0;
            busy    <= 1'b1;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // Pointer wraps back to 0 naturally after the last word.
                    cptr    <= cptr + ADDR_W'(1);
                    q       <= '0;
                    q_valid <= 1'b0;
                    if (&cptr) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (clr) begin
                        state   <= ST_CLEAR;
                        cptr    <= '0;
                        busy    <= 1'b1;
                        q       <= '0;
                        q_valid <= 1'b0;
                    end else if (re) begin
                        q       <= merged;
                        q_valid <= 1'b1;
                    end else begin
                        q       <= '0;
                        q_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bank.sv
// ---------------------------------------------------------------------------
// tb_dmem_bank
//
// Self-checking bench for dmem_bank (DATA_W=32, ADDR_W=6). A behavioural
// model tracks the memory contents, the remaining clear cycles and the
// expected read port; every cycle the DUT outputs are compared with it.
// Directed scenarios add checks against fixed values, followed by a
// randomized traffic phase.
// ---------------------------------------------------------------------------
module tb_dmem_bank;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] a   = '0;
    logic [DW-1:0] d   = '0;
    logic          we  = 1'b0;
    logic [3:0]    be  = '0;
    logic          re  = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] q;
    logic          q_valid;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] model [DEPTH];
    int            clearLeft = 0;
    logic [DW-1:0] expQ  = '0;
    logic          expQv = 1'b0;

    dmem_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .d       (d),
        .we      (we),
        .be      (be),
        .re      (re),
        .clr     (clr),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: memory zeroing is applied as soon as a sweep starts; nothing
    // can observe the array during a sweep, so the end result is the same.
    task automatic modelEdge(input logic r, input logic c, input logic w, input logic rd,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] byteEn);
        logic [DW-1:0] mask;
        logic [DW-1:0] word;
        if (!r) begin
            clearLeft = DEPTH;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            expQ = '0; expQv = 1'b0;
        end else if (clearLeft > 0) begin
            clearLeft--;
            expQ = '0; expQv = 1'b0;
        end else if (c) begin
            clearLeft = DEPTH;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            expQ = '0; expQv = 1'b0;
        end else begin
            mask = {{8{byteEn[3]}}, {8{byteEn[2]}}, {8{byteEn[1]}}, {8{byteEn[0]}}};
            word = model[addr];
            if (w) begin
                word = (word & ~mask) | (data & mask);
                model[addr] = word;
            end
            if (rd) begin
                expQ = word; expQv = 1'b1;
            end else begin
                expQ = '0; expQv = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs, clock edge, advance model, check.
    task automatic applyStimulus(input logic r, input logic c, input logic w, input logic rd,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [3:0] byteEn);
        rst = r; clr = c; we = w; re = rd; a = addr; d = data; be = byteEn;
        @(posedge clk);
        modelEdge(r, c, w, rd, addr, data, byteEn);
        #1;
        checkOutput("q", q, expQ);
        checkOutput("q_valid", {31'b0, q_valid}, {31'b0, expQv});
        checkOutput("busy", {31'b0, busy}, {31'b0, (clearLeft > 0)});
    endtask

    task automatic stepIdle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'b0);
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] byteEn);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, addr, data, byteEn);
    endtask

    task automatic doRead(input logic [AW-1:0] addr);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, addr, '0, 4'b0);
    endtask

    // Counts busy cycles, the current sample included, until busy drops.
    task automatic countBusy(output int n);
        n = busy ? 1 : 0;
        for (int i = 0; i < 200 && busy; i++) begin
            stepIdle();
            if (busy) n++;
        end
    endtask

    // Runs a clear sweep started by clr, with a dropped write, a dropped
    // read and a second clr inside it; optionally resets at sweep cycle rstAt.
    task automatic runSweep(input int rstAt, output int n);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 4'b0);
        n = busy ? 1 : 0;
        for (int k = 1; k < 300 && busy; k++) begin
            if (k == rstAt) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 4'b0);
                n = busy ? 1 : 0;
            end else begin
                if (k == 10)      doWrite(6'd3, 32'hFFFF_FFFF, 4'hF);
                else if (k == 15) begin
                    doRead(6'd3);
                    checkOutput("sweep_read_qv", {31'b0, q_valid}, 32'd0);
                end
                else if (k == 30) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 4'b0);
                else              stepIdle();
                if (busy) n++;
            end
        end
    endtask

    task automatic readAllZero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            doRead(AW'(i));
            checkOutput(tag, q, 32'd0);
        end
    endtask

    task automatic fillNonZero();
        for (int i = 0; i < DEPTH; i++) doWrite(AW'(i), $urandom() | 32'h1, 4'hF);
    endtask

    initial begin
        int n;
        logic [3:0] rbe;

        // Reset held for 3 cycles, then the post-reset sweep
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 4'b0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd1);
        checkOutput("reset_qv", {31'b0, q_valid}, 32'd0);
        countBusy(n);
        checkOutput("reset_busy_len", n, 32'd64);

        doRead(6'h00); checkOutput("rd00", q, 32'd0); checkOutput("rd00_qv", {31'b0, q_valid}, 32'd1);
        doRead(6'h2A); checkOutput("rd2A", q, 32'd0);
        doRead(6'h3F); checkOutput("rd3F", q, 32'd0);

        // Basic write then read, low byte lane
        doWrite(6'h12, 32'h0000_00A5, 4'b0001);
        doRead(6'h12);
        checkOutput("basic_q", q, 32'h0000_00A5);
        checkOutput("basic_qv", {31'b0, q_valid}, 32'd1);
        stepIdle();
        checkOutput("idle_q", q, 32'd0);
        checkOutput("idle_qv", {31'b0, q_valid}, 32'd0);

        // Byte enables
        doWrite(6'd5, 32'h1122_3344, 4'b1111);
        doWrite(6'd5, 32'hFFFF_AAFF, 4'b0010);
        doRead(6'd5);
        checkOutput("be_merge", q, 32'h1122_AA44);

        // Write-first forwarding
        doWrite(6'd7, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 6'd7, 32'h0000_003C, 4'b0001);
        checkOutput("fwd_q", q, 32'hDEAD_BE3C);
        doRead(6'd7);
        checkOutput("fwd_stored", q, 32'hDEAD_BE3C);

        // Runtime clear with ignored traffic and a second clr
        fillNonZero();
        runSweep(0, n);
        checkOutput("clr_busy_len", n, 32'd64);
        readAllZero("clr_zero");

        // Reset in the middle of a sweep
        fillNonZero();
        runSweep(20, n);
        checkOutput("midrst_busy_len", n, 32'd64);
        readAllZero("midrst_zero");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rbe = 4'($urandom());
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 79) == 0),
                          1'($urandom()), 1'($urandom()),
                          ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom()),
                          $urandom(), rbe);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_bank.md
# dmem_bank

Parametrised synchronous data memory for the pipeline's MEM stage. It is the next generation of the 8-bit/64-entry data RAM and adds configurable width and depth, per-byte write enables, and a registered read port with write-first forwarding. A sequential clear engine zeroes the array one word per cycle after reset or on request, and reports `busy` while it runs.

## Interface
- `DATA_W`, default 8: word width in bits; must be a multiple of 8.
- `ADDR_W`, default 6: address width; DEPTH = 2**ADDR_W words.
- `NB`: derived, DATA_W/8, the number of byte lanes.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `a` in ADDR_W: word address shared by read and write.
- `d` in DATA_W: write data.
- `we` in 1: write request.
- `be` in NB: byte-lane enables; bit i gates d[8i+7:8i]. Ignored when `we`=0.
- `re` in 1: read request.
- `clr` in 1: one-cycle pulse that starts a full clear sweep.
- `q` out DATA_W: registered read data.
- `q_valid` out 1: high for exactly the cycle in which `q` holds read data.
- `busy` out 1: high while the clear engine owns the array.

## Operation
- Two states: IDLE and CLEAR. The clear pointer `cptr` is ADDR_W bits wide.
- Reset (sampled `rst`=0):
  - Next state is CLEAR with `cptr`=0.
  - `busy`=1, `q`=0, `q_valid`=0.
  - No array write happens in a reset cycle.
- CLEAR:
  - Each cycle writes 0 to mem[cptr], then increments `cptr`.
  - The cycle that writes mem[DEPTH-1] moves the state to IDLE. `cptr` wraps to 0.
  - `we`, `re` and `clr` are ignored. `q`=0, `q_valid`=0.
- IDLE, `clr`=1:
  - Enters CLEAR with `cptr`=0.
  - Any `we`/`re` in the same cycle is dropped.
- IDLE, `we`=1: for each i with be[i]=1, the lane mem[a][8i+7:8i] takes d[8i+7:8i]. Lanes with be[i]=0 are unchanged.
- IDLE, `re`=1:
  - `q` is loaded with mem[a], `q_valid` is set to 1.
  - Read-during-write to the same address is write-first. `q` returns the merged word: new bytes where be=1, old bytes elsewhere.
- IDLE, `re`=0: `q` is loaded with 0, `q_valid` is set to 0. This matches the zero-when-not-reading behaviour of the previous RAM, now registered.
- Simultaneous `we`+`re` with no conflict is legal. Both execute, and the read returns merged data as above.

## Timing
- Read latency is 1 cycle: `re` sampled at edge N gives `q`/`q_valid` valid after edge N, for cycle N+1 only.
- Write latency: data written at edge N is visible to a read sampled at edge N (forwarded) or at any later edge.
- Clear duration:
  - After the last reset cycle, `busy` is 1 for exactly DEPTH cycles, then drops.
  - A `clr` sampled at edge N gives `busy`=1 from cycle N+1 through cycle N+DEPTH.
- `busy` is a registered output. Upstream logic must stall MEM-stage accesses while `busy`=1; accesses made during that time are lost.
- Reset asserted mid-sweep restarts the sweep at `cptr`=0, giving a full DEPTH-cycle sweep after release.
- `clr` asserted while `busy`=1 is ignored. It does not extend or restart the sweep.
- Out-of-range conditions do not exist: every `a` value addresses a valid word.

## Test plan
- Reset release, defaults: hold `rst`=0 for 3 cycles, then release. `busy`=1 for exactly 64 cycles. Reads of addresses 0x00, 0x2A and 0x3F then return 0 with `q_valid`=1.
- Basic write and read, DATA_W=8: write 0xA5 at address 0x12, read 0x12 on the next cycle. `q`=0xA5 one cycle after the read edge. The following cycle with `re`=0 gives `q`=0, `q_valid`=0.
- Byte enables, DATA_W=32: write 0x11223344 with be=4'b1111 to address 5. Then write 0xFFFFAAFF with be=4'b0010 to address 5. A read of address 5 returns 0x1122AA44.
- Forwarding, DATA_W=32: word 7 holds 0xDEADBEEF. Same cycle: `we`=1, `re`=1, a=7, d=0x0000003C, be=4'b0001. Next cycle `q`=0xDEADBE3C.
- Runtime clear:
  - Fill addresses 0–63 with nonzero data, then pulse `clr`.
  - `busy`=1 for 64 cycles. A write issued during the sweep has no effect, and a read during the sweep gives `q_valid`=0. A second `clr` pulse does not lengthen the sweep.
  - Afterwards all 64 words read 0.
- Reset mid-sweep: assert `rst`=0 for 1 cycle at sweep cycle 20. After release, `busy` stays 1 for 64 further cycles, and all words read 0.
